// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - load-request stream, core debug write port and status bundle for prog_loader
interface prog_loader_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [XLEN-1:0] base_addr;
    logic            in_valid;
    logic [XLEN-1:0] in_data;
    logic            in_last;
    logic            in_ready;
    logic            dbg_wr_en;
    logic [XLEN-1:0] dbg_addr;
    logic [XLEN-1:0] dbg_instr;
    logic            core_rst;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, base_addr, in_valid, in_data, in_last,
        input  in_ready, dbg_wr_en, dbg_addr, dbg_instr, core_rst, busy, done, err
    );

    modport slave (
        input  start, base_addr, in_valid, in_data, in_last,
        output in_ready, dbg_wr_en, dbg_addr, dbg_instr, core_rst, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams program words into a core's instruction memory, then releases core reset
module prog_loader #(
    parameter int XLEN          = 32,
    parameter int MAX_WORDS     = 256,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    prog_loader_if.slave   bus
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        SETTLE = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] instr_q;
    logic            last_q;
    logic [CW-1:0]   count_q;
    logic [3:0]      settle_q;
    logic            core_rst_q;

    logic start_ok;
    logic base_ok;
    logic handshake;
    logic count_full;
    logic settle_done;

    always_comb begin
        start_ok    = 1'b0;
        base_ok     = 1'b0;
        handshake   = 1'b0;
        count_full  = 1'b0;
        settle_done = 1'b0;
        state_nx    = state;

        start_ok    = bus.start && (state == IDLE || state == RUN || state == ERR);
        base_ok     = (bus.base_addr[1:0] == 2'b00);
        handshake   = (state == LOAD) && bus.in_valid;
        // The word in WRITE is the (count_q+1)-th; it fills the load when that equals MAX_WORDS.
        count_full  = (count_q == CW'(MAX_WORDS - 1));
        settle_done = (settle_q == 4'(SETTLE_CYCLES - 1));

        case (state)
            IDLE, RUN, ERR: begin
                if (start_ok) begin
                    state_nx = base_ok ? LOAD : ERR;
                end
            end
            LOAD: begin
                if (handshake) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (last_q) begin
                    state_nx = SETTLE;
                end else if (count_full) begin
                    state_nx = ERR;
                end else begin
                    state_nx = LOAD;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            instr_q    <= '0;
            last_q     <= 1'b0;
            count_q    <= '0;
            settle_q   <= '0;
            core_rst_q <= 1'b1;
        end else begin
            // Registered from the next state so a restart from RUN re-asserts it one cycle later.
            core_rst_q <= (state_nx != RUN);

            if (start_ok && base_ok) begin
                addr_q  <= bus.base_addr;
                count_q <= '0;
            end

            if (handshake) begin
                instr_q <= bus.in_data;
                last_q  <= bus.in_last;
            end

            if (state == WRITE) begin
                addr_q   <= addr_q + XLEN'(4);
                count_q  <= count_q + CW'(1);
                settle_q <= '0;
            end else if (state == SETTLE) begin
                settle_q <= settle_q + 4'd1;
            end
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.dbg_wr_en = (state == WRITE);
    assign bus.dbg_addr  = addr_q;
    assign bus.dbg_instr = instr_q;
    assign bus.core_rst  = core_rst_q;
    assign bus.busy      = (state == LOAD) || (state == WRITE) || (state == SETTLE);
    assign bus.done      = (state == RUN);
    assign bus.err       = (state == ERR);
endmodule
